// File: rtl/kinase_ctrl_pkg.sv
// Shared widths, step-table layout, pump patterns and sequencer states.
// Pure declarations; no logic, no latency.
// No handshakes live here.
package kinase_ctrl_pkg;

  localparam int CTRL_A_W = 13;
  localparam int CTRL_S_W = 4;
  localparam int DEPTH    = 16;
  localparam int IDX_W    = 4;
  localparam int LEN_W    = 5;
  localparam int DWELL_W  = 16;
  localparam int CYC_W    = 8;
  localparam int STEP_W   = 43;

  // One step-table entry, laid out exactly as the host writes cfg_data.
  typedef struct packed {
    logic [CTRL_A_W-1:0] ctrl_a;
    logic [CTRL_S_W-1:0] ctrl_s;
    logic [1:0]          pump_sel;
    logic [CYC_W-1:0]    pump_cycles;
    logic [DWELL_W-1:0]  dwell;
  } step_t;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_A     = 2'b01;
  localparam logic [1:0] SEL_B     = 2'b10;
  localparam logic [1:0] SEL_NONE2 = 2'b11;

  localparam int PUMP_A_PHASES = 6;
  localparam int PUMP_B_PHASES = 4;

  // Element 0 is the first phase of each pattern.
  localparam logic [0:5][2:0] PUMP_A_PAT = {3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
  localparam logic [0:3][1:0] PUMP_B_PAT = {2'b10, 2'b11, 2'b01, 2'b00};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_PUMP  = 3'd2,
    ST_DWELL = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // A step pumps only for a real pump selection with a non-zero cycle count.
  function automatic logic pump_active(input logic [1:0] sel, input logic [CYC_W-1:0] cyc);
    return ((sel == SEL_A) || (sel == SEL_B)) && (cyc != '0);
  endfunction

endpackage

// File: rtl/kinase_ctrl_sequencer_pump_phase_gen.sv
// Peristaltic pump pattern generator: PHASE_TICKS clocks per phase, `cycles` full patterns.
// Outputs follow counters with no extra delay; last flags the final clock of the final cycle.
// No backpressure; dropping en clears every counter so the next step starts at phase 0.
module pump_phase_gen
  import kinase_ctrl_pkg::*;
#(
  parameter int PHASE_TICKS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [CYC_W-1:0] cycles,
  output logic [2:0]       pump_a,
  output logic [1:0]       pump_b,
  output logic             last
);

  localparam int TICK_W = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [2:0]        phase_q, phase_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [2:0]        phase_last;
  logic              tick_wrap;
  logic              phase_wrap;

  // Wrap detection and end-of-pumping flag.
  always_comb begin
    phase_last = (sel == SEL_B) ? 3'(PUMP_B_PHASES - 1) : 3'(PUMP_A_PHASES - 1);
    tick_wrap  = (tick_q == TICK_LAST);
    phase_wrap = tick_wrap && (phase_q == phase_last);
    last       = en && phase_wrap && (cyc_q == cycles - CYC_W'(1));
  end

  // Tick -> phase -> cycle counting; idle clears so nothing carries between steps.
  always_comb begin
    tick_d  = tick_q;
    phase_d = phase_q;
    cyc_d   = cyc_q;
    if (!en) begin
      tick_d  = '0;
      phase_d = '0;
      cyc_d   = '0;
    end else if (tick_wrap) begin
      tick_d = '0;
      if (phase_wrap) begin
        phase_d = '0;
        cyc_d   = cyc_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      phase_q <= '0;
      cyc_q   <= '0;
    end else begin
      tick_q  <= tick_d;
      phase_q <= phase_d;
      cyc_q   <= cyc_d;
    end
  end

  // Only the selected pump moves; the other is held at zero.
  always_comb begin
    pump_a = '0;
    pump_b = '0;
    if (en && (sel == SEL_A)) pump_a = PUMP_A_PAT[phase_q];
    if (en && (sel == SEL_B)) pump_b = PUMP_B_PAT[phase_q[1:0]];
  end

endmodule

// File: rtl/kinase_ctrl_sequencer.sv
// Step-table valve/pump sequencer: plays len steps of apply/pump/dwell, then pulses done.
// Step length is 1 + pump_cycles*phases*PHASE_TICKS + dwell clocks; outputs follow state directly.
// Table writes are refused (cfg_ready low) while a run is in progress; abort wins over everything.
module kinase_ctrl_sequencer
  import kinase_ctrl_pkg::*;
#(
  parameter int PHASE_TICKS = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic [STEP_W-1:0]   cfg_data,
  input  logic [LEN_W-1:0]    run_len,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    step_idx,
  output logic [CTRL_A_W-1:0] ctrl_a,
  output logic [CTRL_S_W-1:0] ctrl_s,
  output logic [2:0]          pump_a,
  output logic [1:0]          pump_b
);

  step_t               tab_q [DEPTH];
  state_e              state_q, state_d, adv_state;
  logic [IDX_W-1:0]    step_q, step_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  step_t               cur;
  logic                has_pump, has_dwell, dwell_done, last_step, step_go;
  logic                pump_en, pump_last;
  logic [2:0]          pump_a_raw;
  logic [1:0]          pump_b_raw;

  // Step table: host writes only land while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready) tab_q[cfg_addr] <= cfg_data;
  end

  // Decode of the step currently being played.
  always_comb begin
    cur        = tab_q[step_q];
    has_pump   = pump_active(cur.pump_sel, cur.pump_cycles);
    has_dwell  = (cur.dwell != '0);
    dwell_done = (dwell_q == cur.dwell - DWELL_W'(1));
    last_step  = ({1'b0, step_q} == len_q - LEN_W'(1));
    adv_state  = last_step ? ST_FIN : ST_APPLY;
    step_go    = ((state_q == ST_APPLY) && !has_pump && !has_dwell) ||
                 ((state_q == ST_PUMP) && pump_last && !has_dwell) ||
                 ((state_q == ST_DWELL) && dwell_done);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort overrides start and completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = (run_len == '0) ? ST_FIN : ST_APPLY;
      ST_APPLY: begin
        if (has_pump)       state_d = ST_PUMP;
        else if (has_dwell) state_d = ST_DWELL;
        else                state_d = adv_state;
      end
      ST_PUMP:  if (pump_last) state_d = has_dwell ? ST_DWELL : adv_state;
      ST_DWELL: if (dwell_done) state_d = adv_state;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Run length, step index and dwell counter; dwell restarts from zero on every step.
  always_comb begin
    len_d   = len_q;
    step_d  = step_q;
    dwell_d = '0;
    if ((state_q == ST_IDLE) && start) begin
      len_d  = (run_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : run_len;
      step_d = '0;
    end else if (step_go && !last_step) begin
      step_d = step_q + 1'b1;
    end
    if ((state_q == ST_DWELL) && !dwell_done) dwell_d = dwell_q + 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
    end else begin
      len_q   <= len_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
    end
  end

  assign pump_en = (state_q == ST_PUMP);

  pump_phase_gen #(
    .PHASE_TICKS(PHASE_TICKS)
  ) u_pump (
    .clk    (clk),
    .rst    (rst),
    .en     (pump_en),
    .sel    (cur.pump_sel),
    .cycles (cur.pump_cycles),
    .pump_a (pump_a_raw),
    .pump_b (pump_b_raw),
    .last   (pump_last)
  );

  // Outputs: everything safe (zero) outside APPLY/PUMP/DWELL.
  always_comb begin
    busy      = (state_q == ST_APPLY) || (state_q == ST_PUMP) || (state_q == ST_DWELL);
    done      = (state_q == ST_FIN);
    cfg_ready = !busy;
    step_idx  = busy ? step_q : '0;
    ctrl_a    = busy ? cur.ctrl_a : '0;
    ctrl_s    = busy ? cur.ctrl_s : '0;
    pump_a    = pump_a_raw;
    pump_b    = pump_b_raw;
  end

endmodule

// File: tb/tb_kinase_ctrl_sequencer.sv
// Self-checking bench: a per-cycle trace model built from the step table, plus pinned literals.
module tb_kinase_ctrl_sequencer;

  localparam int PT = 2;
  // Observed vector: {busy, done, step_idx[3:0], ctrl_a[12:0], ctrl_s[3:0], pump_a[2:0], pump_b[1:0], cfg_ready}
  localparam logic [28:0] IDLE_V = 29'h0000001;
  localparam logic [28:0] FIN_V  = 29'h8000001;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, cfg_ready, start, abort, busy, done;
  logic [3:0]  cfg_addr, step_idx, ctrl_s;
  logic [42:0] cfg_data;
  logic [4:0]  run_len;
  logic [12:0] ctrl_a;
  logic [2:0]  pump_a;
  logic [1:0]  pump_b;
  logic [28:0] dut_v;

  always #5 clk = ~clk;

  kinase_ctrl_sequencer #(.PHASE_TICKS(PT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .run_len(run_len),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .step_idx(step_idx), .ctrl_a(ctrl_a), .ctrl_s(ctrl_s),
    .pump_a(pump_a), .pump_b(pump_b)
  );

  assign dut_v = {busy, done, step_idx, ctrl_a, ctrl_s, pump_a, pump_b, cfg_ready};

  logic [42:0] tab_m [16];
  logic [28:0] q [$];
  logic [28:0] exp_cur = IDLE_V;
  logic [28:0] hist [19];
  logic [2:0]  pat_a [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
  logic [1:0]  pat_b [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  int          n_chk = 0;
  int          n_pass = 0;
  bit          chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
  endtask

  function automatic logic [28:0] mk(input bit b, input bit d, input int s, input logic [12:0] a,
                                     input logic [3:0] cs, input logic [2:0] pa, input logic [1:0] pb);
    return {b, d, 4'(s), a, cs, pa, pb, ~b};
  endfunction

  // Expand a run into the exact per-cycle output trace it must produce.
  function automatic void push_run(input int rl);
    int len;
    len = (rl > 16) ? 16 : rl;
    if (len == 0) begin
      q.push_back(FIN_V);
      return;
    end
    for (int s = 0; s < len; s++) begin
      logic [42:0] w;
      int nph;
      w = tab_m[s];
      nph = (w[25:24] == 2'b01) ? 6 : (w[25:24] == 2'b10) ? 4 : 0;
      q.push_back(mk(1, 0, s, w[42:30], w[29:26], 3'b0, 2'b0));
      if (nph != 0)
        for (int c = 0; c < int'(w[23:16]); c++)
          for (int p = 0; p < nph; p++)
            for (int t = 0; t < PT; t++)
              q.push_back(mk(1, 0, s, w[42:30], w[29:26],
                             (nph == 6) ? pat_a[p] : 3'b0, (nph == 4) ? pat_b[p] : 2'b0));
      for (int d = 0; d < int'(w[15:0]); d++)
        q.push_back(mk(1, 0, s, w[42:30], w[29:26], 3'b0, 2'b0));
    end
    q.push_back(FIN_V);
  endfunction

  // Every cycle: the DUT must match the next trace entry, or be idle when the trace is empty.
  always @(negedge clk) begin
    if (chk_en) begin
      if (q.size() != 0) exp_cur = q.pop_front();
      else               exp_cur = IDLE_V;
      chk("cycle", 64'(dut_v), 64'(exp_cur));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int addr, input logic [42:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_data  = data;
    @(posedge clk);
    if (exp_cur[0]) tab_m[addr] = data;
    #1 cfg_valid = 1'b0;
  endtask

  task automatic do_start(input int rl);
    run_len = 5'(rl);
    start   = 1'b1;
    @(posedge clk);
    if ((q.size() == 0) && (exp_cur == IDLE_V)) push_run(rl);
    #1 start = 1'b0;
  endtask

  task automatic abort_now();
    abort = 1'b1;
    @(posedge clk);
    q.delete();
    #1 abort = 1'b0;
  endtask

  task automatic reset_now();
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    q.delete();
  endtask

  function automatic logic [42:0] rnd_step();
    return {13'($urandom), 4'($urandom), 2'($urandom), 8'($urandom_range(0, 2)), 16'($urandom_range(0, 4))};
  endfunction

  initial begin
    int mx, n;
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    run_len = '0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'(dut_v), 64'(IDLE_V));
    rst = 1'b0;
    chk_en = 1;

    // Pump A step then a bare step.
    write(0, {13'h1001, 4'h3, 2'b01, 8'd1, 16'd3});
    write(1, {13'h0002, 4'h0, 2'b00, 8'd0, 16'd0});
    do_start(2);
    hist[1] = dut_v;
    for (int k = 2; k <= 18; k++) begin
      tick();
      hist[k] = dut_v;
    end
    chk("t1_ctrl_a_c1", 64'(hist[1][22:10]), 64'h1001);
    chk("t1_ctrl_s_c1", 64'(hist[1][9:6]), 64'h3);
    chk("t1_pump_a_c1", 64'(hist[1][5:3]), 64'h0);
    chk("t1_pump_a_c2", 64'(hist[2][5:3]), 64'b110);
    chk("t1_pump_a_c3", 64'(hist[3][5:3]), 64'b110);
    chk("t1_pump_a_c4", 64'(hist[4][5:3]), 64'b100);
    chk("t1_pump_a_c13", 64'(hist[13][5:3]), 64'b010);
    chk("t1_pump_a_c14", 64'(hist[14][5:3]), 64'b000);
    chk("t1_ctrl_a_c16", 64'(hist[16][22:10]), 64'h1001);
    chk("t1_ctrl_a_c17", 64'(hist[17][22:10]), 64'h0002);
    chk("t1_fin_c18", 64'(hist[18]), 64'(FIN_V));
    wait_done(50);

    // Pump B, 2 cycles: step length 1 + 2*4*2 = 17.
    write(0, {13'h0abc, 4'h5, 2'b10, 8'd2, 16'd0});
    do_start(1);
    hist[1] = dut_v;
    for (int k = 2; k <= 18; k++) begin
      tick();
      hist[k] = dut_v;
    end
    chk("t2_pump_b_c2", 64'(hist[2][2:1]), 64'b10);
    chk("t2_pump_b_c4", 64'(hist[4][2:1]), 64'b11);
    chk("t2_pump_b_c6", 64'(hist[6][2:1]), 64'b01);
    chk("t2_pump_b_c8", 64'(hist[8][2:1]), 64'b00);
    chk("t2_pump_b_c10", 64'(hist[10][2:1]), 64'b10);
    chk("t2_pump_a_c5", 64'(hist[5][5:3]), 64'b000);
    chk("t2_busy_c17", 64'(hist[17][28]), 64'd1);
    chk("t2_fin_c18", 64'(hist[18]), 64'(FIN_V));
    wait_done(50);

    // Zero-length run.
    do_start(0);
    chk("t3_len0_fin", 64'(dut_v), 64'(FIN_V));
    tick();
    chk("t3_len0_idle", 64'(dut_v), 64'(IDLE_V));
    wait_done(10);

    // run_len beyond table depth clamps to 16 steps.
    for (int i = 0; i < 16; i++) write(i, rnd_step());
    do_start(20);
    mx = 0;
    n = 0;
    while ((q.size() != 0) && (n < 2000)) begin
      if (busy && (int'(step_idx) > mx)) mx = int'(step_idx);
      tick();
      n++;
    end
    chk("t4_max_step", 64'(mx), 64'd15);
    wait_done(10);

    // Abort mid-pump, then rerun from step 0.
    write(0, {13'h1abc, 4'h9, 2'b01, 8'd3, 16'd2});
    do_start(1);
    repeat (5) tick();
    chk("t5_pump_before_abort", 64'(pump_a), 64'b101);
    abort_now();
    chk("t5_abort_busy", 64'(busy), 64'd0);
    chk("t5_abort_outs", 64'({done, ctrl_a, ctrl_s, pump_a, pump_b}), 64'd0);
    repeat (3) tick();
    do_start(1);
    chk("t5_rerun_idx", 64'(step_idx), 64'd0);
    chk("t5_rerun_ctrl_a", 64'(ctrl_a), 64'h1abc);
    wait_done(200);

    // Writes and starts while busy are ignored.
    write(0, {13'h0111, 4'h1, 2'b00, 8'd0, 16'd10});
    do_start(1);
    tick();
    chk("t6_busy_rdy", 64'(cfg_ready), 64'd0);
    write(0, {13'h1fff, 4'hf, 2'b01, 8'd1, 16'd1});
    do_start(3);
    wait_done(100);
    do_start(1);
    chk("t6_table_kept", 64'(ctrl_a), 64'h0111);
    wait_done(100);

    // Reset in the middle of a dwell.
    write(0, {13'h0222, 4'h2, 2'b00, 8'd0, 16'd20});
    do_start(1);
    repeat (4) tick();
    chk("t7_dwell_ctrl_a", 64'(ctrl_a), 64'h0222);
    reset_now();
    chk("t7_rst_ctrl_a", 64'(ctrl_a), 64'd0);
    chk("t7_rst_rdy", 64'(cfg_ready), 64'd1);
    repeat (2) tick();

    // Randomized runs with random writes, starts and aborts.
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 4; w++) write($urandom_range(0, 15), rnd_step());
      do_start($urandom_range(0, 20));
      repeat ($urandom_range(1, 40)) tick();
      if ($urandom_range(0, 2) == 0) do_start($urandom_range(0, 20));
      if ($urandom_range(0, 2) == 0) write($urandom_range(0, 15), rnd_step());
      if ($urandom_range(0, 2) == 0) abort_now();
      wait_done(3000);
    end

    // Maximum pump cycles and dwell: 1 + 255*4*2 + 65535 = 67576 clocks, FIN on cycle 67577.
    write(0, {13'h0333, 4'h4, 2'b10, 8'd255, 16'hffff});
    do_start(1);
    n = 1;
    while (!done && (n < 70000)) begin
      tick();
      n++;
    end
    chk("t9_max_step_len", 64'(n), 64'd67577);
    wait_done(10);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
